dyn_patt_gen: RTL and testbench

Serial pattern generator that drives the `data`/`valid` stream consumed by the dynamic pattern detector (`dyn_patt`). It shifts a NUM_BITS-wide, runtime-loadable pattern out MSB first for a programmed number of repetitions, with an optional idle gap between repetitions and a stall input. It serves as the transmit end for detector benches and for loopback tests of the detector.

---
 rtl/dyn_patt_gen.sv | 151 +++++++++++++++
 tb/tb_dyn_patt_gen.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dyn_patt_gen.sv
// Serial pattern generator: shifts a loadable NUM_BITS pattern out MSB first for a
// programmed number of repetitions, with optional inter-repetition gap and stall.
module dyn_patt_gen #(
    parameter int                    NUM_BITS = 5,
    parameter logic [NUM_BITS-1:0]   PATTERN  = 5'b10110,
    parameter int                    CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pat_load,
    input  logic [NUM_BITS-1:0] pat_in,
    input  logic [CNT_W-1:0]    reps,
    input  logic [CNT_W-1:0]    gap,
    input  logic                stall,
    output logic                data,
    output logic                valid,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    sent_cnt
);

    localparam int IDX_W = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [NUM_BITS-1:0] pat, pat_nxt, pat_eff;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [CNT_W-1:0]    reps_q, reps_nxt;
    logic [CNT_W-1:0]    gap_q, gap_nxt;
    logic [CNT_W-1:0]    gap_cnt, gap_cnt_nxt;
    logic [CNT_W-1:0]    sent_nxt;
    logic                data_nxt, valid_nxt, busy_nxt, done_nxt;

    // A load coinciding with start must be the pattern that gets sent.
    assign pat_eff = pat_load ? pat_in : pat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pat      <= PATTERN;
            idx      <= '0;
            reps_q   <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            sent_cnt <= '0;
            data     <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pat      <= pat_nxt;
            idx      <= idx_nxt;
            reps_q   <= reps_nxt;
            gap_q    <= gap_nxt;
            gap_cnt  <= gap_cnt_nxt;
            sent_cnt <= sent_nxt;
            data     <= data_nxt;
            valid    <= valid_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pat_nxt     = pat;
        idx_nxt     = idx;
        reps_nxt    = reps_q;
        gap_nxt     = gap_q;
        gap_cnt_nxt = gap_cnt;
        sent_nxt    = sent_cnt;
        data_nxt    = data;
        valid_nxt   = valid;
        busy_nxt    = busy;
        done_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (pat_load) begin
                    pat_nxt = pat_in;
                end
                if (start && (reps != '0)) begin
                    reps_nxt  = reps;
                    gap_nxt   = gap;
                    sent_nxt  = '0;
                    idx_nxt   = MSB_IDX;
                    data_nxt  = pat_eff[NUM_BITS-1];
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = SEND;
                end
            end

            SEND: begin
                if (stall) begin
                    valid_nxt = 1'b0;
                end else if (idx != '0) begin
                    idx_nxt   = idx - 1'b1;
                    data_nxt  = pat[idx - 1'b1];
                    valid_nxt = 1'b1;
                    if (idx == IDX_W'(1)) begin
                        sent_nxt = sent_cnt + 1'b1;
                    end
                end else if (sent_cnt != reps_q) begin
                    // Bit 0 already out and repetitions remain.
                    if (gap_q == '0) begin
                        idx_nxt   = MSB_IDX;
                        data_nxt  = pat[NUM_BITS-1];
                        valid_nxt = 1'b1;
                    end else begin
                        gap_cnt_nxt = gap_q - 1'b1;
                        data_nxt    = 1'b0;
                        valid_nxt   = 1'b0;
                        state_nxt   = GAP;
                    end
                end else begin
                    data_nxt  = 1'b0;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end

            GAP: begin
                if (gap_cnt == '0) begin
                    idx_nxt   = MSB_IDX;
                    data_nxt  = pat[NUM_BITS-1];
                    valid_nxt = 1'b1;
                    state_nxt = SEND;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dyn_patt_gen.sv
// Scoreboard bench for dyn_patt_gen: expected bits queued per burst, checked as valid bits appear.
module tb_dyn_patt_gen;

    localparam int NB = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          pat_load;
    logic [NB-1:0] pat_in;
    logic [CW-1:0] reps;
    logic [CW-1:0] gap;
    logic          stall;
    logic          data;
    logic          valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] sent_cnt;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];
    logic [NB-1:0] model_pat;

    dyn_patt_gen #(.NUM_BITS(NB), .PATTERN(5'b10110), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .pat_load(pat_load), .pat_in(pat_in),
        .reps(reps), .gap(gap), .stall(stall), .data(data), .valid(valid),
        .busy(busy), .done(done), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Drive one burst and check it; mid_poke pokes pat_load/start while busy,
    // rst_at != 0 fires an async reset once that many valid bits have been seen.
    task automatic run_burst(input int r, input int g, input int stall_n,
                             input bit mid_poke, input int rst_at);
        int busy_cyc = 0;
        int valid_cyc = 0;
        int stall_left = 0;
        bit stall_done = 0;
        bit seen_done = 0;
        for (int i = 0; i < r; i++)
            for (int b = NB - 1; b >= 0; b--)
                exp_q.push_back(model_pat[b]);
        @(posedge clk); #1;
        start = 1'b1; reps = CW'(r); gap = CW'(g);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2000 && !seen_done; k++) begin
            @(negedge clk);
            if (done) seen_done = 1;
            if (busy) busy_cyc++;
            if (valid) begin
                valid_cyc++;
                if (exp_q.size() == 0) chk("extra_bit", 1, 0);
                else chk("data", 32'(data), 32'(exp_q.pop_front()));
            end
            if (mid_poke) begin
                if (busy_cyc == 2) begin
                    pat_load = 1'b1; pat_in = ~model_pat; start = 1'b1;
                end else begin
                    pat_load = 1'b0; start = 1'b0;
                end
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) stall = 1'b0;
            end else if (!stall_done && stall_n > 0 && valid_cyc == 2) begin
                stall = 1'b1; stall_left = stall_n; stall_done = 1;
            end
            if (rst_at != 0 && valid_cyc == rst_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_busy", 32'(busy), 0);
                chk("rst_valid", 32'(valid), 0);
                chk("rst_data", 32'(data), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_sent", 32'(sent_cnt), 0);
                exp_q.delete();
                model_pat = 5'b10110;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        chk("done_seen", 32'(seen_done), 1);
        chk("busy_span", busy_cyc, r * NB + (r - 1) * g + stall_n);
        chk("valid_cnt", valid_cyc, r * NB);
        chk("sent_cnt", 32'(sent_cnt), r);
        chk("q_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pat_load = 1'b0; pat_in = '0;
        reps = '0; gap = '0; stall = 1'b0;
        model_pat = 5'b10110;
        #12;
        chk("reset_valid", 32'(valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_data", 32'(data), 0);
        chk("reset_sent", 32'(sent_cnt), 0);
        @(negedge clk); rst = 1'b0;

        run_burst(1, 0, 0, 0, 0);   // single default pattern
        run_burst(3, 0, 0, 0, 0);   // continuous triple
        run_burst(2, 2, 0, 0, 0);   // gap between repetitions

        @(posedge clk); #1;
        pat_load = 1'b1; pat_in = 5'b11001;
        @(posedge clk); #1;
        pat_load = 1'b0;
        model_pat = 5'b11001;
        run_burst(1, 0, 0, 1, 0);   // new pattern, mid-burst load/start ignored
        run_burst(1, 0, 0, 0, 0);   // pattern still 11001 afterwards
        run_burst(1, 0, 3, 0, 0);   // stall for 3 cycles after second bit

        // start with reps=0 is ignored
        @(posedge clk); #1;
        start = 1'b1; reps = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reps0_busy", 32'(busy), 0);
            chk("reps0_valid", 32'(valid), 0);
            chk("reps0_done", 32'(done), 0);
        end
        chk("reps0_sent", 32'(sent_cnt), 1);

        run_burst(2, 0, 0, 0, 8);   // reset during 3rd bit of rep 2
        run_burst(1, 1, 0, 0, 0);   // reset restored default pattern

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
